// File: rtl/rd_fifo_pkg.sv
// Shared constants for the single-clock read-return FIFO: read modes, default
// geometry/thresholds and the count-width helper.
package rd_fifo_pkg;

  localparam bit MODE_STD  = 1'b0;
  localparam bit MODE_FWFT = 1'b1;

  localparam int DEF_DATA_WIDTH    = 128;
  localparam int DEF_ADDR_WIDTH    = 6;
  localparam int DEF_WRITE_BURST   = 8;
  localparam int DEF_AFULL_THRESH  = 56;
  localparam int DEF_AEMPTY_THRESH = 2;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/rd_fifo_ram.sv
// Simple dual-port storage for rd_fifo_sync: one write port, one registered
// read port whose output holds its value between reads.
module rd_fifo_ram
  import rd_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; contents are
  // meaningless until written, which the pointer logic guarantees.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register must read 0 out of reset, so only it carries a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rd_fifo_sync.sv
// Single-clock read-return FIFO, standard or FWFT read mode, with registered
// flags. Define RD_FIFO_BURST_EN to enable the burst_avail comparator.
module rd_fifo_sync
  import rd_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int WRITE_BURST   = DEF_WRITE_BURST,
  parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH,
  parameter int FWFT          = int'(MODE_STD)
) (
  input  logic                  rd_clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] rd_fifo_in,
  input  logic                  rd_fifo_vd,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rd_fifo_out,
  output logic                  fifo_out_vd,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  burst_avail,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int CW        = clog2(DEPTH + 1);
  localparam bit FWFT_MODE = (FWFT == int'(MODE_FWFT));

  logic [CW-1:0] wr_ptr, rd_ptr, count_nxt;
  logic          wr_acc, rd_acc, ram_re, ram_empty, vd_nxt, empty_nxt;

  assign wr_acc    = rd_fifo_vd & ~full;
  assign rd_acc    = rd_en & ~empty;
  assign ram_empty = (wr_ptr == rd_ptr);

  // In FWFT mode the RAM read refills the output register whenever it is
  // empty or being popped, so the read-data register doubles as that stage.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch forms.
    ram_re = rd_acc;
    vd_nxt = rd_acc;
    if (FWFT_MODE) begin
      ram_re = (~fifo_out_vd | rd_acc) & ~ram_empty;
      vd_nxt = ram_re | (fifo_out_vd & ~rd_acc);
    end
  end

  // Count covers RAM plus the FWFT output word, so full/empty derive from it;
  // in standard mode it equals the pointer distance.
  assign count_nxt = data_count + CW'(wr_acc) - CW'(rd_acc);
  assign empty_nxt = FWFT_MODE ? ~vd_nxt : (count_nxt == '0);

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      fifo_out_vd  <= 1'b0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (ram_re) rd_ptr <= rd_ptr + CW'(1);
      data_count   <= count_nxt;
      fifo_out_vd  <= vd_nxt;
      full         <= (count_nxt == CW'(DEPTH));
      almost_full  <= (count_nxt >= CW'(AFULL_THRESH));
      empty        <= empty_nxt;
      almost_empty <= (count_nxt <= CW'(AEMPTY_THRESH));
      // A fresh error outranks a simultaneous clear.
      overflow     <= (rd_fifo_vd & full) | (overflow & ~clr_err);
      underflow    <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end

`ifdef RD_FIFO_BURST_EN
  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) burst_avail <= 1'b0;
    else          burst_avail <= (count_nxt >= CW'(WRITE_BURST));
  end
`else
  assign burst_avail = 1'b0;
`endif

  rd_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (rd_clk),
    .rst_n(reset_n),
    .we   (wr_acc),
    .waddr(wr_ptr[ADDR_WIDTH-1:0]),
    .wdata(rd_fifo_in),
    .re   (ram_re),
    .raddr(rd_ptr[ADDR_WIDTH-1:0]),
    .rdata(rd_fifo_out)
  );

endmodule

// File: tb/tb_rd_fifo_sync.sv
// Bench for rd_fifo_sync: one standard-mode and one FWFT instance on a shared
// clock, checked against a queue-based model of the FIFO rules.
module tb_rd_fifo_sync;

`ifdef RD_FIFO_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif
  localparam int DEPTH = 64;

  logic rd_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // standard-mode instance
  logic [127:0] s_din = '0, s_out;
  logic s_vd = 0, s_en = 0, s_clr = 0;
  logic s_ovd, s_full, s_af, s_empty, s_ae, s_burst, s_ovf, s_unf;
  logic [6:0] s_count;

  // FWFT instance
  logic [127:0] f_din = '0, f_out;
  logic f_vd = 0, f_en = 0, f_clr = 0;
  logic f_ovd, f_full, f_af, f_empty, f_ae, f_burst, f_ovf, f_unf;
  logic [6:0] f_count;

  rd_fifo_sync #(.FWFT(0)) dut_std (
    .rd_clk(rd_clk), .reset_n(reset_n), .rd_fifo_in(s_din), .rd_fifo_vd(s_vd),
    .rd_en(s_en), .clr_err(s_clr), .rd_fifo_out(s_out), .fifo_out_vd(s_ovd),
    .full(s_full), .almost_full(s_af), .empty(s_empty), .almost_empty(s_ae),
    .data_count(s_count), .burst_avail(s_burst), .overflow(s_ovf), .underflow(s_unf)
  );

  rd_fifo_sync #(.FWFT(1)) dut_fwft (
    .rd_clk(rd_clk), .reset_n(reset_n), .rd_fifo_in(f_din), .rd_fifo_vd(f_vd),
    .rd_en(f_en), .clr_err(f_clr), .rd_fifo_out(f_out), .fifo_out_vd(f_ovd),
    .full(f_full), .almost_full(f_af), .empty(f_empty), .almost_empty(f_ae),
    .data_count(f_count), .burst_avail(f_burst), .overflow(f_ovf), .underflow(f_unf)
  );

  int checks = 0;
  int errors = 0;

  // reference model of the standard instance
  logic [127:0] sq[$];
  logic [127:0] m_out = '0;
  bit m_vd = 0, m_ovf = 0, m_unf = 0;
  logic [127:0] fq[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_std();
    int n;
    n = sq.size();
    chk("s_count", 128'(s_count), 128'(n));
    chk("s_full", 128'(s_full), 128'(n == DEPTH));
    chk("s_afull", 128'(s_af), 128'(n >= 56));
    chk("s_empty", 128'(s_empty), 128'(n == 0));
    chk("s_aempty", 128'(s_ae), 128'(n <= 2));
    chk("s_burst", 128'(s_burst), 128'(BURST_ON && n >= 8));
    chk("s_ovf", 128'(s_ovf), 128'(m_ovf));
    chk("s_unf", 128'(s_unf), 128'(m_unf));
    chk("s_out_vd", 128'(s_ovd), 128'(m_vd));
    chk("s_out", s_out, m_out);
  endtask

  // One clock on the standard instance; model applies the FIFO rules to the
  // pre-edge occupancy, then every output is compared.
  task automatic s_step(input bit vd, input logic [127:0] din, input bit en, input bit clr);
    int n;
    s_vd = vd; s_din = din; s_en = en; s_clr = clr;
    @(posedge rd_clk); #1;
    n = sq.size();
    m_ovf = (vd && n == DEPTH) || (m_ovf && !clr);
    m_unf = (en && n == 0) || (m_unf && !clr);
    m_vd = en && n > 0;
    if (m_vd) m_out = sq.pop_front();
    if (vd && n < DEPTH) sq.push_back(din);
    chk_std();
    s_vd = 0; s_en = 0; s_clr = 0;
  endtask

  task automatic f_cycle(input bit vd, input logic [127:0] din, input bit en);
    f_vd = vd; f_din = din; f_en = en;
    @(posedge rd_clk); #1;
    f_vd = 0; f_en = 0;
  endtask

  task automatic chk_f_lvl(input int n);
    chk("f_count", 128'(f_count), 128'(n));
    chk("f_full", 128'(f_full), 128'(n == DEPTH));
    chk("f_afull", 128'(f_af), 128'(n >= 56));
    chk("f_aempty", 128'(f_ae), 128'(n <= 2));
    chk("f_burst", 128'(f_burst), 128'(BURST_ON && n >= 8));
  endtask

  initial begin
    logic [127:0] w;

    // reset state of both instances
    #12;
    chk_std();
    chk("f_empty_rst", 128'(f_empty), 128'(1));
    chk("f_vd_rst", 128'(f_ovd), 128'(0));
    chk("f_ovf_rst", 128'(f_ovf), 128'(0));
    chk_f_lvl(0);
    @(negedge rd_clk); reset_n = 1'b1;
    @(posedge rd_clk); #1;

    // FWFT: single write appears two edges later
    w = rnd128();
    f_cycle(1, w, 0);
    chk("f_vd_n1", 128'(f_ovd), 128'(0));
    chk("f_empty_n1", 128'(f_empty), 128'(1));
    chk_f_lvl(1);
    f_cycle(0, '0, 0);
    chk("f_vd_n2", 128'(f_ovd), 128'(1));
    chk("f_out_n2", f_out, w);
    chk("f_empty_n2", 128'(f_empty), 128'(0));
    f_cycle(0, '0, 1);
    chk("f_vd_pop", 128'(f_ovd), 128'(0));
    chk("f_empty_pop", 128'(f_empty), 128'(1));
    chk_f_lvl(0);
    f_cycle(0, '0, 1);
    chk("f_unf", 128'(f_unf), 128'(1));
    chk_f_lvl(0);

    // FWFT: 16 words, then pops on consecutive cycles with no bubble
    for (int i = 0; i < 16; i++) begin
      fq.push_back(rnd128());
      f_cycle(1, fq[i], 0);
      chk_f_lvl(i + 1);
    end
    f_cycle(0, '0, 0);
    for (int i = 0; i < 16; i++) begin
      chk("f_vd_b2b", 128'(f_ovd), 128'(1));
      chk("f_out_b2b", f_out, fq[i]);
      f_cycle(0, '0, 1);
      chk_f_lvl(15 - i);
    end
    chk("f_vd_end", 128'(f_ovd), 128'(0));
    chk("f_empty_end", 128'(f_empty), 128'(1));

    // standard: fill 0..63, one dropped write, drain in order
    for (int i = 0; i < DEPTH; i++) s_step(1, 128'(i), 0, 0);
    s_step(1, 128'hdead, 0, 0);
    for (int i = 0; i < DEPTH; i++) s_step(0, '0, 1, 0);
    s_step(0, '0, 0, 0);

    // read on empty with a write in the same cycle; then clear errors
    s_step(1, rnd128(), 1, 0);
    s_step(0, '0, 0, 1);

    // steady occupancy of 5 under simultaneous write+read
    for (int i = 0; i < 4; i++) s_step(1, rnd128(), 0, 0);
    for (int i = 0; i < 10; i++) s_step(1, rnd128(), 1, 0);

    // full: write+read+clear in one cycle; the dropped write re-sets overflow
    while (sq.size() < DEPTH) s_step(1, rnd128(), 0, 0);
    s_step(1, rnd128(), 1, 1);
    s_step(0, '0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      s_step(($urandom_range(0, 99) < 55), rnd128(), ($urandom_range(0, 99) < 50),
             ($urandom_range(0, 99) < 5));
    end

    // asynchronous reset mid-stream clears the count before the next edge
    for (int i = 0; i < 10; i++) s_step(1, rnd128(), 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("s_count_async", 128'(s_count), 128'(0));
    chk("s_empty_async", 128'(s_empty), 128'(1));
    chk("s_vd_async", 128'(s_ovd), 128'(0));
    @(negedge rd_clk); reset_n = 1'b1;
    sq.delete();
    m_out = '0; m_vd = 0; m_ovf = 0; m_unf = 0;
    s_step(0, '0, 0, 0);
    for (int i = 0; i < 3; i++) s_step(1, 128'(i + 100), 0, 0);
    for (int i = 0; i < 3; i++) s_step(0, '0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rd_fifo_sync.md
Name: rd_fifo_sync

Overview:
Single-clock, parametrised read-return FIFO between the DDR2 controller read-data path and the user read port; successor to the dual-clock rd_fifo wrapper.
- Native RTL storage (inferred RAM, registered read); no vendor core.
- Adds a consumer-driven rd_en, standard/FWFT read mode, programmable almost thresholds, occupancy count, sticky error flags and a burst-available indication.

Parameters:
- DATA_WIDTH, 128, data word width in bits.
- ADDR_WIDTH, 6, log2 of storage depth (DEPTH = 2**ADDR_WIDTH = 64).
- WRITE_BURST, 8, words per DDR2 burst; threshold for burst_avail.
- AFULL_THRESH, 56, almost_full asserts when data_count >= AFULL_THRESH.
- AEMPTY_THRESH, 2, almost_empty asserts when data_count <= AEMPTY_THRESH.
- FWFT, 0, read mode: 0 = standard (1-cycle read latency), 1 = first-word-fall-through.

Ports:
- rd_clk  in  1  single clock for all logic.
- reset_n  in  1  reset; asynchronous, active-low.
- rd_fifo_in  in  DATA_WIDTH  write data from controller.
- rd_fifo_vd  in  1  write strobe; one word per cycle.
- rd_en  in  1  read request from consumer.
- clr_err  in  1  synchronous clear of overflow/underflow.
- rd_fifo_out  out  DATA_WIDTH  read data.
- fifo_out_vd  out  1  rd_fifo_out valid.
- full  out  1  storage full.
- almost_full  out  1  see AFULL_THRESH.
- empty  out  1  no readable word.
- almost_empty  out  1  see AEMPTY_THRESH.
- data_count  out  ADDR_WIDTH+1  words held (0..DEPTH).
- burst_avail  out  1  at least WRITE_BURST words held.
- overflow  out  1  sticky: write dropped while full.
- underflow  out  1  sticky: read requested while empty.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Pointers and count cleared to 0.
  - rd_fifo_out = 0, fifo_out_vd = 0, full = 0, almost_full = 0, empty = 1, almost_empty = 1.
  - data_count = 0, burst_avail = 0, overflow = 0, underflow = 0.
  - Reset mid-operation discards all contents. Release is synchronous to rd_clk; no spurious write or read on the first cycle after release.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits and wrap naturally at 2*DEPTH.
  - full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal.
- Write accepted: rd_fifo_vd & !full. Write while full is dropped and sets overflow, including when a read occurs in the same cycle.
- Read accepted: rd_en & !empty.
  - Read while empty is ignored and sets underflow, including when a write occurs in the same cycle.
  - A simultaneous accepted write and read leaves data_count unchanged.
- data_count is registered. All flags are registered and derived from the next-state count, so they are valid in the same cycle as data_count.
- clr_err clears overflow/underflow next cycle. A new error in the same cycle as clr_err wins (flag stays 1).
- FWFT=0:
  - Accepted read at cycle N gives rd_fifo_out and fifo_out_vd=1 at N+1.
  - fifo_out_vd is a 1-cycle pulse per read; rd_fifo_out holds its last value otherwise.
  - empty reflects RAM occupancy.
- FWFT=1:
  - A one-word output register prefetches the head word.
  - fifo_out_vd is level: 1 while the output register holds a word. rd_en acts as a pop acknowledge.
  - Write into a completely empty FIFO at cycle N gives fifo_out_vd=1 at N+2.
  - A pop with further words queued refills the register the next cycle, so back-to-back pops sustain 1 word/cycle.
  - empty = !fifo_out_vd. data_count includes the output-register word.
- Data order is strictly FIFO; there is no data loss except dropped overflow writes.

Optional Feature:
- RD_FIFO_BURST_EN defined: burst_avail is a registered (data_count >= WRITE_BURST), updated alongside data_count.
- Undefined: burst_avail is tied to 0 and the comparator logic is removed. The port is still present.

Decomposition:
- Package rd_fifo_pkg:
  - Read-mode constants (MODE_STD=0, MODE_FWFT=1).
  - Default widths and thresholds.
  - Count-type width function clog2.
- Sub-module rd_fifo_ram: simple dual-port RAM, one write port, registered read port, DATA_WIDTH x DEPTH. Pointer, flag and FWFT control logic stays in rd_fifo_sync.

Test Plan:
- Reset with default params -> empty=1, almost_empty=1, data_count=0, all other outputs 0; async assert mid-stream clears the count to 0 within the same cycle.
- FWFT=0: write 64 words 0..63 -> full=1 and almost_full=1 (from count 56); 65th write dropped, overflow=1; read 64 words -> data 0..63, each fifo_out_vd one cycle after rd_en; empty=1 at end.
- FWFT=0 at count 5: simultaneous write+read for 10 cycles -> data_count stays 5, order preserved; rd_en on empty with rd_fifo_vd high -> underflow=1, write accepted, count=1.
- FWFT=1: single write at cycle N -> fifo_out_vd=1 and rd_fifo_out=word at N+2; 16 words with rd_en held high -> 16 consecutive valid cycles with no bubble after the first.
- clr_err pulse -> overflow/underflow clear next cycle; clr_err coincident with a new overflow -> overflow stays 1.
- RD_FIFO_BURST_EN defined: count 7->8 -> burst_avail 0->1 in the same cycle data_count=8; undefined -> burst_avail always 0.
